// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Pipeline request/response and memory-port signal bundle for
//               the load/store unit. The slave modport is the unit's own view
//               (it serves pipeline requests and drives the memory port);
//               master is the view of the surrounding pipeline and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Pipeline side
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    // Memory side
    logic                  mem_req;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RV32I load/store unit. Accepts one access at a time, rejects
//               illegal or misaligned accesses without touching memory,
//               issues legal accesses as lane-replicated word transfers with
//               byte enables, and returns sign/zero-extended load data or an
//               error on memory timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);

    // Counter value on the last WAIT cycle before the access is declared lost
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                state;
    logic [7:0]            wait_cnt;
    logic                  saved_we;
    logic [2:0]            saved_funct3;
    logic [1:0]            saved_lane;

    logic [1:0]            req_lane;
    logic                  req_legal;
    logic                  req_misaligned;
    logic [3:0]            req_be;
    logic [DATA_WIDTH-1:0] req_wdata_rep;

    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [DATA_WIDTH-1:0] load_data;

    assign req_lane      = bus.req_addr[1:0];
    assign bus.req_ready = (state == IDLE);

    // Decode the incoming request: legality, alignment, byte enables and lane replication
    always_comb begin
        req_legal      = 1'b0;
        req_misaligned = 1'b0;
        req_be         = 4'b0000;
        req_wdata_rep  = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                req_be        = 4'b0001 << req_lane;
                req_wdata_rep = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                req_be         = 4'b0011 << req_lane;
                req_wdata_rep  = {2{bus.req_wdata[15:0]}};
                req_misaligned = req_lane[0];
            end
            2'b10: begin
                req_be         = 4'b1111;
                req_misaligned = |req_lane;
            end
            default: begin
                req_be = 4'b0000;
            end
        endcase
        if (bus.req_we) begin
            req_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                        (bus.req_funct3 == 3'b010);
        end else begin
            req_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                        (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                        (bus.req_funct3 == 3'b101);
        end
    end

    // Pick the addressed lane out of the returned word and extend it
    always_comb begin
        lane_byte = bus.mem_rdata[{saved_lane, 3'b000} +: 8];
        lane_half = saved_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (saved_funct3)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b010:  load_data = bus.mem_rdata;
            3'b100:  load_data = {24'd0, lane_byte};
            3'b101:  load_data = {16'd0, lane_half};
            default: load_data = '0;
        endcase
    end

    // Access sequencer with registered memory-port and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            wait_cnt       <= 8'd0;
            saved_we       <= 1'b0;
            saved_funct3   <= 3'b000;
            saved_lane     <= 2'b00;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_be     <= 4'b0000;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= 8'd0;
                    if (bus.req_valid) begin
                        saved_we     <= bus.req_we;
                        saved_funct3 <= bus.req_funct3;
                        saved_lane   <= req_lane;
                        if (!req_legal || req_misaligned) begin
                            // Rejected accesses never reach memory
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                        end else begin
                            state         <= ISSUE;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.req_we;
                            bus.mem_be    <= req_be;
                            bus.mem_addr  <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                            bus.mem_wdata <= req_wdata_rep;
                        end
                    end
                end
                ISSUE: begin
                    // Request fields stay frozen until the memory grants
                    if (bus.mem_gnt) begin
                        state       <= WAIT;
                        wait_cnt    <= 8'd0;
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        bus.mem_be  <= 4'b0000;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= saved_we ? '0 : load_data;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                        bus.resp_rdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. A per-access model
//               predicts error, byte enables, replicated store data, extended
//               load data and the cycle of every handshake event; a negedge
//               compare process checks all outputs against it every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   done = 1'b0;

    // Expectations for the access in flight (cycle numbers are absolute)
    int          e_acc = -1;
    int          e_gnt = -1;
    int          e_resp = -1;
    logic        e_legal = 1'b0;
    logic        e_err = 1'b0;
    logic        e_we = 1'b0;
    logic [3:0]  e_be = 4'h0;
    logic [31:0] e_addr = 32'h0;
    logic [31:0] e_wdata = 32'h0;
    logic [31:0] e_rdata = 32'h0;

    bit exp_req, exp_rv, exp_ready;

    load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    load_store_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural view of one access, from the RV32I width/sign rules
    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rword,
                                  output logic err, output logic [3:0] be,
                                  output logic [31:0] mw, output logic [31:0] rd);
        int          size;
        int          off;
        logic        legal;
        logic [31:0] v;
        logic [31:0] mask;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = int'(addr % 32'd4);
        err   = !legal || ((off % size) != 0);
        be    = 4'h0;
        mw    = 32'h0;
        rd    = 32'h0;
        if (!err) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + size) be[i] = 1'b1;
                mw[8*i +: 8] = wdata[8*(i % size) +: 8];
            end
            if (!we) begin
                v    = rword >> (8 * off);
                mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
                v    = v & mask;
                if (size < 4 && f3[2] == 1'b0 && v[8*size-1]) v = v | ~mask;
                rd = v;
            end
        end
    endfunction

    // Compare every output against the model on every cycle
    always @(negedge clk) begin
        if (!done) begin
            exp_req   = e_legal && (cyc > e_acc) && (cyc <= e_gnt);
            exp_rv    = (cyc == e_resp);
            exp_ready = !((cyc > e_acc) && (cyc <= e_resp));
            chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            chk("mem_req", 32'(bus.mem_req), 32'(exp_req));
            chk("mem_addr_lsb", 32'(bus.mem_addr[1:0]), 32'd0);
            if (exp_req) begin
                chk("mem_we", 32'(bus.mem_we), 32'(e_we));
                chk("mem_be", 32'(bus.mem_be), 32'(e_be));
                chk("mem_addr", bus.mem_addr, e_addr);
                chk("mem_wdata", bus.mem_wdata, e_wdata);
            end else begin
                chk("mem_be_idle", 32'(bus.mem_be), 32'd0);
            end
            chk("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
            if (exp_rv) begin
                chk("resp_err", 32'(bus.resp_err), 32'(e_err));
                chk("resp_rdata", bus.resp_rdata, e_rdata);
            end else begin
                chk("resp_err_idle", 32'(bus.resp_err), 32'd0);
                chk("resp_rdata_idle", bus.resp_rdata, 32'd0);
            end
        end
    end

    // One access: gd = cycles gnt is withheld, rd = WAIT cycles before rvalid
    // (-1: never), junk = spurious rvalid alongside gnt, rst_at = cycle offset
    // at which reset is asserted (-1: none)
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rword,
                           input int gd, input int rd, input bit junk, input int rst_at);
        logic        err;
        logic [3:0]  be;
        logic [31:0] mw;
        logic [31:0] rdat;
        int          acc;
        int          gnt_c;
        int          rv_c;
        int          done_c;
        bit          finished;
        model(we, f3, addr, wdata, rword, err, be, mw, rdat);
        @(posedge clk);
        #1;
        acc = cyc;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        if (err) begin
            gnt_c  = -1;
            rv_c   = -1;
            e_resp = acc + 1;
        end else begin
            gnt_c  = acc + 1 + gd;
            rv_c   = (rd < 0) ? -1 : gnt_c + 1 + rd;
            e_resp = (rd < 0) ? gnt_c + 1 + TIMEOUT : rv_c + 1;
        end
        e_acc   = acc;
        e_gnt   = gnt_c;
        e_legal = !err;
        e_err   = (rd < 0) ? 1'b1 : err;
        e_we    = we;
        e_be    = be;
        e_addr  = {addr[31:2], 2'b00};
        e_wdata = mw;
        e_rdata = (rd < 0) ? 32'h0 : rdat;
        done_c  = (rst_at >= 0) ? acc + rst_at + 4 : e_resp;
        finished = 1'b0;
        for (int k = 0; k < 300 && !finished; k++) begin
            @(posedge clk);
            #1;
            bus.req_valid  = 1'b0;
            bus.mem_gnt    = (cyc == gnt_c);
            bus.mem_rvalid = (cyc == rv_c) || (junk && cyc == gnt_c);
            bus.mem_rdata  = (cyc == rv_c) ? rword : 32'h1111_1111;
            if (rst_at >= 0) begin
                if (cyc == acc + rst_at) begin
                    rst_n   = 1'b0;
                    e_gnt   = -1;
                    e_resp  = -1;
                    e_legal = 1'b0;
                    gnt_c   = -1;
                end
                if (cyc == acc + rst_at + 2) rst_n = 1'b1;
                if (cyc == acc + rst_at + 3) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = 32'hCAFE_F00D;
                end
            end
            if (cyc == done_c) finished = 1'b1;
        end
        chk("txn_bound", 32'(finished), 32'd1);
    endtask

    initial begin
        logic        er;
        logic [3:0]  pbe;
        logic [31:0] pmw;
        logic [31:0] prd;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Hand-computed values that pin the model
        model(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, er, pbe, pmw, prd);
        chk("pin_lw_rdata", prd, 32'hDEAD_BEEF);
        chk("pin_lw_err", 32'(er), 32'd0);
        model(1'b1, 3'b000, 32'h13, 32'h0000_00A5, 32'h0, er, pbe, pmw, prd);
        chk("pin_sb_be", 32'(pbe), 32'h8);
        chk("pin_sb_wdata", pmw, 32'hA5A5_A5A5);
        model(1'b0, 3'b001, 32'h12, 32'h0, 32'h80FF_0000, er, pbe, pmw, prd);
        chk("pin_lh_rdata", prd, 32'hFFFF_80FF);
        model(1'b0, 3'b101, 32'h12, 32'h0, 32'h80FF_0000, er, pbe, pmw, prd);
        chk("pin_lhu_rdata", prd, 32'h0000_80FF);
        model(1'b0, 3'b000, 32'h13, 32'h0, 32'h80FF_0000, er, pbe, pmw, prd);
        chk("pin_lb_rdata", prd, 32'hFFFF_FF80);
        model(1'b1, 3'b010, 32'h02, 32'h0, 32'h0, er, pbe, pmw, prd);
        chk("pin_sw_misaligned", 32'(er), 32'd1);
        model(1'b0, 3'b011, 32'h00, 32'h0, 32'h0, er, pbe, pmw, prd);
        chk("pin_ld_illegal", 32'(er), 32'd1);

        // Directed accesses, issued back to back
        run_txn(1'b0, 3'b010, 32'h10, 32'h0,         32'hDEAD_BEEF, 0, 0, 1'b0, -1); // lw
        run_txn(1'b1, 3'b000, 32'h13, 32'h0000_00A5, 32'h5555_5555, 0, 0, 1'b0, -1); // sb
        run_txn(1'b0, 3'b001, 32'h12, 32'h0,         32'h80FF_0000, 1, 1, 1'b0, -1); // lh
        run_txn(1'b0, 3'b101, 32'h12, 32'h0,         32'h80FF_0000, 0, 2, 1'b0, -1); // lhu
        run_txn(1'b0, 3'b000, 32'h13, 32'h0,         32'h80FF_0000, 0, 0, 1'b0, -1); // lb
        run_txn(1'b0, 3'b100, 32'h11, 32'h0,         32'h1234_5678, 0, 0, 1'b0, -1); // lbu
        run_txn(1'b0, 3'b000, 32'h21, 32'h0,         32'h0000_9A00, 0, 0, 1'b0, -1); // lb
        run_txn(1'b1, 3'b001, 32'h06, 32'h1234_BEEF, 32'h0,         2, 0, 1'b0, -1); // sh
        run_txn(1'b1, 3'b010, 32'h08, 32'hCAFE_BABE, 32'h0,         0, 1, 1'b0, -1); // sw
        run_txn(1'b1, 3'b010, 32'h02, 32'h1,         32'h0,         0, 0, 1'b0, -1); // sw misaligned
        run_txn(1'b0, 3'b011, 32'h00, 32'h0,         32'h0,         0, 0, 1'b0, -1); // illegal load
        run_txn(1'b1, 3'b100, 32'h04, 32'h0,         32'h0,         0, 0, 1'b0, -1); // illegal store
        run_txn(1'b0, 3'b010, 32'h11, 32'h0,         32'h0,         0, 0, 1'b0, -1); // lw misaligned
        run_txn(1'b0, 3'b001, 32'h15, 32'h0,         32'h0,         0, 0, 1'b0, -1); // lh misaligned
        run_txn(1'b0, 3'b010, 32'h40, 32'h0,         32'h0BAD_CAFE, 3, 2, 1'b1, -1); // gnt held off, early rvalid
        run_txn(1'b0, 3'b010, 32'h44, 32'h0,         32'h0,         3, -1, 1'b0, -1); // timeout
        run_txn(1'b0, 3'b010, 32'h20, 32'h0,         32'h0,         0, -1, 1'b0, 3); // reset in WAIT
        run_txn(1'b0, 3'b010, 32'h24, 32'h0,         32'h7654_3210, 0, 0, 1'b0, -1); // after reset

        @(posedge clk);
        #1;
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
